// File: rtl/judge_arbiter.sv
// rtl/judge_arbiter.sv - shared answer comparator sequencer and hit-point keeper for one quiz round
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   STATE               controller state bus (READY 0010, QUESTION 0011, INPUT 0100, WRONG 0111)
//   NEW_GAME            synchronous restart: reload HP, clear results, latches and FSM
//   EXP_ANS             expected answer, stable during INPUT
//   P_DEC, P_ANS        player submit pulse and answer
//   C_VALID, C_ANS      CPU submit pulse and answer
//   P_ACK, C_ACK        one-cycle pulse after a submission is latched
//   JUDG                00 none, 01 GOOD, 10 OUCH, 11 DRAW
//   WRONG               11 while a wrong player answer is being reported
//   HP_STAT             00 playing, 01 CPU exhausted, 10 player exhausted (sticky)
//   P_HP, C_HP          current hit points
module judge_arbiter #(
    parameter int W       = 8,
    parameter int HPW     = 3,
    parameter int HP_INIT = 3
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [3:0]     STATE,
    input  logic           NEW_GAME,
    input  logic [W-1:0]   EXP_ANS,
    input  logic           P_DEC,
    input  logic [W-1:0]   P_ANS,
    input  logic           C_VALID,
    input  logic [W-1:0]   C_ANS,
    output logic           P_ACK,
    output logic           C_ACK,
    output logic [1:0]     JUDG,
    output logic [1:0]     WRONG,
    output logic [1:0]     HP_STAT,
    output logic [HPW-1:0] P_HP,
    output logic [HPW-1:0] C_HP
);

    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_CHK_P   = 3'd2;
    localparam logic [2:0] S_CHK_C   = 3'd3;
    localparam logic [2:0] S_RESULT  = 3'd4;

    localparam logic [HPW-1:0] HP_LOAD = HPW'(HP_INIT);
    localparam logic [HPW-1:0] HP_ONE  = HPW'(1);

    logic [2:0]   fsm;
    logic [3:0]   prev_state;
    logic         p_pend;
    logic         c_pend;
    logic [W-1:0] p_ans_q;
    logic [W-1:0] c_ans_q;
    logic         p_ok;
    logic         res_entry;   // high for the cycle right after JUDG was loaded

    logic collecting;
    logic p_acc;
    logic c_acc;
    logic round_start;

    assign collecting  = (fsm == S_COLLECT) || (fsm == S_CHK_P) || (fsm == S_CHK_C);
    assign p_acc       = P_DEC   && !p_pend && collecting && !NEW_GAME;
    assign c_acc       = C_VALID && !c_pend && collecting && !NEW_GAME;
    assign round_start = (prev_state == ST_QUESTION) && (STATE == ST_INPUT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fsm        <= S_IDLE;
            prev_state <= 4'b0000;
            p_pend     <= 1'b0;
            c_pend     <= 1'b0;
            p_ans_q    <= '0;
            c_ans_q    <= '0;
            p_ok       <= 1'b0;
            res_entry  <= 1'b0;
            P_ACK      <= 1'b0;
            C_ACK      <= 1'b0;
            JUDG       <= 2'b00;
            WRONG      <= 2'b00;
            HP_STAT    <= 2'b00;
            P_HP       <= HP_LOAD;
            C_HP       <= HP_LOAD;
        end else begin
            prev_state <= STATE;
            P_ACK      <= p_acc;
            C_ACK      <= c_acc;
            if (NEW_GAME) begin
                fsm       <= S_IDLE;
                p_pend    <= 1'b0;
                c_pend    <= 1'b0;
                p_ok      <= 1'b0;
                res_entry <= 1'b0;
                JUDG      <= 2'b00;
                WRONG     <= 2'b00;
                HP_STAT   <= 2'b00;
                P_HP      <= HP_LOAD;
                C_HP      <= HP_LOAD;
            end else begin
                res_entry <= 1'b0;
                if (p_acc) begin
                    p_pend  <= 1'b1;
                    p_ans_q <= P_ANS;
                end
                if (c_acc) begin
                    c_pend  <= 1'b1;
                    c_ans_q <= C_ANS;
                end
                // Placed before the FSM so a fresh wrong verdict wins over the release.
                if ((WRONG == 2'b11) && (STATE != ST_INPUT)) begin
                    WRONG <= 2'b00;
                end

                case (fsm)
                    S_IDLE: begin
                        if (STATE == ST_INPUT) fsm <= S_COLLECT;
                    end
                    S_COLLECT: begin
                        if (STATE != ST_INPUT) fsm <= S_IDLE;
                        else if (p_pend)       fsm <= S_CHK_P;
                        else if (c_pend)       fsm <= S_CHK_C;
                    end
                    S_CHK_P: begin
                        if (p_ans_q != EXP_ANS) begin
                            WRONG  <= 2'b11;
                            p_pend <= 1'b0;
                            fsm    <= S_IDLE;
                        end else if (c_pend || c_acc) begin
                            // A CPU answer landing this very edge still gets a chance to draw.
                            p_ok <= 1'b1;
                            fsm  <= S_CHK_C;
                        end else begin
                            JUDG      <= 2'b01;
                            res_entry <= 1'b1;
                            fsm       <= S_RESULT;
                        end
                    end
                    S_CHK_C: begin
                        if (c_ans_q == EXP_ANS) begin
                            JUDG      <= p_ok ? 2'b11 : 2'b10;
                            res_entry <= 1'b1;
                            fsm       <= S_RESULT;
                        end else if (p_ok) begin
                            JUDG      <= 2'b01;
                            res_entry <= 1'b1;
                            fsm       <= S_RESULT;
                        end else begin
                            c_pend <= 1'b0;
                            fsm    <= S_COLLECT;
                        end
                    end
                    S_RESULT: begin
                        if (STATE == ST_READY) begin
                            JUDG   <= 2'b00;
                            p_ok   <= 1'b0;
                            p_pend <= 1'b0;
                            c_pend <= 1'b0;
                            fsm    <= S_IDLE;
                        end
                    end
                    default: fsm <= S_IDLE;
                endcase

                if (res_entry) begin
                    if ((JUDG == 2'b01) && (C_HP != '0)) begin
                        C_HP <= C_HP - HP_ONE;
                        if ((C_HP == HP_ONE) && (HP_STAT == 2'b00)) HP_STAT <= 2'b01;
                    end
                    if ((JUDG == 2'b10) && (P_HP != '0)) begin
                        P_HP <= P_HP - HP_ONE;
                        if ((P_HP == HP_ONE) && (HP_STAT == 2'b00)) HP_STAT <= 2'b10;
                    end
                end

                if (round_start) begin
                    p_pend <= 1'b0;
                    c_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_judge_arbiter.sv
// tb/tb_judge_arbiter.sv - self-checking bench for judge_arbiter
module tb_judge_arbiter;

    localparam logic [3:0] ST_RDY = 4'b0010;
    localparam logic [3:0] ST_Q   = 4'b0011;
    localparam logic [3:0] ST_IN  = 4'b0100;
    localparam logic [3:0] ST_WR  = 4'b0111;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] STATE;
    logic       NEW_GAME;
    logic [7:0] EXP_ANS;
    logic       P_DEC;
    logic [7:0] P_ANS;
    logic       C_VALID;
    logic [7:0] C_ANS;
    logic       P_ACK;
    logic       C_ACK;
    logic [1:0] JUDG;
    logic [1:0] WRONG;
    logic [1:0] HP_STAT;
    logic [2:0] P_HP;
    logic [2:0] C_HP;

    int checks = 0;
    int errors = 0;
    int m_php  = 3;
    int m_chp  = 3;
    int m_stat = 0;

    judge_arbiter #(.W(8), .HPW(3), .HP_INIT(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .STATE(STATE), .NEW_GAME(NEW_GAME),
        .EXP_ANS(EXP_ANS), .P_DEC(P_DEC), .P_ANS(P_ANS),
        .C_VALID(C_VALID), .C_ANS(C_ANS), .P_ACK(P_ACK), .C_ACK(C_ACK),
        .JUDG(JUDG), .WRONG(WRONG), .HP_STAT(HP_STAT), .P_HP(P_HP), .C_HP(C_HP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference scoring: a GOOD costs the CPU one HP, an OUCH costs the player one,
    // floors at zero, and the first side to hit zero decides the sticky status.
    task automatic model_apply(input logic [1:0] j);
        if (j == 2'b01 && m_chp > 0) begin
            m_chp--;
            if (m_chp == 0 && m_stat == 0) m_stat = 1;
        end
        if (j == 2'b10 && m_php > 0) begin
            m_php--;
            if (m_php == 0 && m_stat == 0) m_stat = 2;
        end
    endtask

    task automatic chk_hp(input string tag);
        chk({tag, "_p_hp"}, P_HP, m_php);
        chk({tag, "_c_hp"}, C_HP, m_chp);
        chk({tag, "_hp_stat"}, HP_STAT, m_stat);
    endtask

    task automatic new_game();
        NEW_GAME = 1'b1;
        tick();
        NEW_GAME = 1'b0;
        m_php = 3; m_chp = 3; m_stat = 0;
    endtask

    task automatic start_round(input logic [7:0] e);
        STATE = ST_Q;
        tick();
        STATE   = ST_IN;
        EXP_ANS = e;
        tick();
    endtask

    task automatic submit(input bit ps, input bit cs, input logic [7:0] pa, input logic [7:0] ca);
        P_DEC   = ps;
        C_VALID = cs;
        if (ps) P_ANS = pa;
        if (cs) C_ANS = ca;
        tick();
        P_DEC   = 1'b0;
        C_VALID = 1'b0;
    endtask

    // One full round: the verdict is simply {CPU correct, player correct};
    // a wrong player answer is reported first and any CPU answer is judged later.
    task automatic play_round(input bit ps, input bit cs, input logic [7:0] e,
                              input logic [7:0] pa, input logic [7:0] ca);
        bit pok;
        bit cok;
        logic [1:0] ej;
        pok = ps && (pa == e);
        cok = cs && (ca == e);
        ej  = {cok, pok};
        start_round(e);
        submit(ps, cs, pa, ca);
        chk("rnd_p_ack", P_ACK, ps);
        chk("rnd_c_ack", C_ACK, cs);
        repeat (3) tick();
        if (ps && !pok) begin
            chk("rnd_wrong_set", WRONG, 2'b11);
            STATE = ST_WR;
            tick();
            chk("rnd_wrong_clr", WRONG, 2'b00);
            STATE = ST_IN;
            repeat (6) tick();
        end else begin
            chk("rnd_wrong_none", WRONG, 2'b00);
            repeat (2) tick();
        end
        chk("rnd_judg", JUDG, ej);
        model_apply(ej);
        chk_hp("rnd");
        STATE = ST_RDY;
        tick();
        chk("rnd_judg_clr", JUDG, 2'b00);
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] pa;
        logic [7:0] ca;
        bit ps;
        bit cs;

        RST_N = 1'b0; STATE = 4'b0000; NEW_GAME = 1'b0; EXP_ANS = 8'd0;
        P_DEC = 1'b0; P_ANS = 8'd0; C_VALID = 1'b0; C_ANS = 8'd0;
        repeat (2) tick();
        chk("reset_judg", JUDG, 2'b00);
        chk("reset_wrong", WRONG, 2'b00);
        chk("reset_p_ack", P_ACK, 1'b0);
        chk("reset_c_ack", C_ACK, 1'b0);
        chk_hp("reset");
        RST_N = 1'b1;
        tick();

        // Single correct player answer with exact latencies.
        start_round(8'd12);
        submit(1'b1, 1'b0, 8'd12, 8'd0);
        chk("good_ack", P_ACK, 1'b1);
        chk("good_judg_n", JUDG, 2'b00);
        tick();
        chk("good_ack_pulse", P_ACK, 1'b0);
        chk("good_judg_n1", JUDG, 2'b00);
        tick();
        chk("good_judg_n2", JUDG, 2'b01);
        chk("good_chp_n2", C_HP, 3);
        tick();
        model_apply(2'b01);
        chk_hp("good_n3");
        STATE = ST_RDY;
        tick();
        chk("good_judg_clr", JUDG, 2'b00);

        // Wrong player answer, WRONG excursion, then a resubmission.
        start_round(8'd12);
        submit(1'b1, 1'b0, 8'd5, 8'd0);
        repeat (2) tick();
        chk("wrong_set", WRONG, 2'b11);
        chk("wrong_no_judg", JUDG, 2'b00);
        STATE = ST_WR;
        tick();
        chk("wrong_clr", WRONG, 2'b00);
        STATE = ST_IN;
        tick();
        submit(1'b1, 1'b0, 8'd12, 8'd0);
        chk("wrong_resubmit_ack", P_ACK, 1'b1);
        repeat (3) tick();
        chk("wrong_resubmit_judg", JUDG, 2'b01);
        model_apply(2'b01);
        chk_hp("wrong_resubmit");
        STATE = ST_RDY;
        tick();
        new_game();
        chk_hp("ng1");

        // Simultaneous correct answers draw.
        play_round(1'b1, 1'b1, 8'd12, 8'd12, 8'd12);

        // CPU wins three rounds, then one extra OUCH at zero.
        for (int i = 0; i < 4; i++) play_round(1'b0, 1'b1, 8'd12, 8'd0, 8'd12);
        new_game();

        // CPU wrong, second CPU submit rejected while latch full, player correct.
        start_round(8'd12);
        submit(1'b0, 1'b1, 8'd0, 8'd7);
        chk("cpu_wrong_ack", C_ACK, 1'b1);
        submit(1'b0, 1'b1, 8'd0, 8'd12);
        chk("cpu_full_noack", C_ACK, 1'b0);
        tick();
        submit(1'b1, 1'b0, 8'd12, 8'd0);
        chk("cpu_then_p_ack", P_ACK, 1'b1);
        repeat (4) tick();
        chk("cpu_then_p_judg", JUDG, 2'b01);
        model_apply(2'b01);
        chk_hp("cpu_then_p");

        // NEW_GAME while RESULT is held.
        new_game();
        chk("ng_judg", JUDG, 2'b00);
        chk("ng_wrong", WRONG, 2'b00);
        chk_hp("ng_result");
        submit(1'b1, 1'b0, 8'd12, 8'd0);
        chk("ng_idle_noack", P_ACK, 1'b0);
        STATE = ST_RDY;
        tick();

        // Asynchronous reset in the middle of CHK_P.
        play_round(1'b1, 1'b0, 8'd12, 8'd12, 8'd0);
        start_round(8'd12);
        submit(1'b1, 1'b1, 8'd12, 8'd12);
        tick();
        RST_N = 1'b0;
        #1;
        m_php = 3; m_chp = 3; m_stat = 0;
        chk("rst_judg", JUDG, 2'b00);
        chk_hp("rst_async");
        tick();
        RST_N = 1'b1;
        repeat (4) tick();
        chk("rst_no_result", JUDG, 2'b00);
        chk_hp("rst_after");
        STATE = ST_RDY;
        tick();

        // Randomized rounds against the reference model.
        for (int i = 0; i < 40; i++) begin
            e  = 8'($urandom_range(0, 255));
            ps = 1'($urandom_range(0, 1));
            cs = 1'($urandom_range(0, 1));
            pa = ($urandom_range(0, 2) != 0) ? e : (e ^ 8'($urandom_range(1, 255)));
            ca = ($urandom_range(0, 2) != 0) ? e : (e ^ 8'($urandom_range(1, 255)));
            play_round(ps, cs, e, pa, ca);
            if (m_stat != 0) begin
                new_game();
                chk_hp("rnd_ng");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/judge_arbiter.md
# judge_arbiter

Sequences the single shared answer comparator between the player keypad path and the CPU opponent path during one quiz round. It produces the judgement, wrong-answer and HP-status codes consumed by the game controller FSM. It also owns both players' hit points across rounds. It watches the controller's 4-bit STATE bus to know when answers are accepted and when a round's result may be cleared.

## Interface
- W, default 8: answer width.
- HPW, default 3: hit-point counter width.
- HP_INIT, default 3: hit points loaded on reset and NEW_GAME. Legal range 1..2^HPW-1.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- STATE  in  4  controller state: 0010 READY, 0011 QUESTION, 0100 INPUT, 0111 WRONG.
- NEW_GAME  in  1  synchronous game restart pulse.
- EXP_ANS  in  W  expected answer from the question generator; stable during INPUT.
- P_DEC, P_ANS  in  1, W  player submit pulse and answer.
- C_VALID, C_ANS  in  1, W  CPU submit pulse and answer.
- P_ACK, C_ACK  out  1  one-cycle pulse: submission latched.
- JUDG  out  2  00 none, 01 player correct (GOOD), 10 CPU correct (OUCH), 11 both correct (DRAW).
- WRONG  out  2  11 = player answered wrong; otherwise 00.
- HP_STAT  out  2  00 playing, 01 CPU HP exhausted (win), 10 player HP exhausted (lose).
- P_HP, C_HP  out  HPW  current hit points.

## Operation
- Reset values: state IDLE, both latches empty, JUDG=00, WRONG=00, HP_STAT=00, P_HP=C_HP=HP_INIT, P_ACK=C_ACK=0.
- Per-side latch (answer + pending flag):
  - A submit pulse is accepted only in COLLECT, CHK_P or CHK_C, and only while that side's latch is empty. On accept, the latch is filled and the side's ACK pulses the next cycle.
  - Submits are otherwise ignored: no ACK.
- Previous STATE is registered. When STATE enters 0100 from 0011, both latches clear; a fresh round starts.
- FSM:
  - IDLE: go to COLLECT when STATE==0100.
  - COLLECT: if STATE!=0100, go to IDLE with latches kept. Else if player pending, go to CHK_P. Else if CPU pending, go to CHK_C. The player has fixed priority.
  - CHK_P compares P_ANS with EXP_ANS:
    - Mismatch: WRONG<=11, clear player latch, go to IDLE.
    - Match with CPU pending: go to CHK_C with p_ok=1.
    - Match with CPU not pending: JUDG<=01, go to RESULT.
  - CHK_C compares C_ANS with EXP_ANS:
    - Match with p_ok: JUDG<=11.
    - Match without p_ok: JUDG<=10.
    - Mismatch with p_ok: JUDG<=01.
    - Mismatch without p_ok: clear CPU latch silently, return to COLLECT.
    - Every match, and any p_ok case, goes to RESULT.
  - RESULT: hold JUDG and block all submits. Go to IDLE when STATE==0010; JUDG<=00 on that transition. Clear p_ok and both latches on that transition.
- WRONG is held at 11 until STATE first differs from 0100 after being set, then returns to 00. The CPU latch survives the controller's WRONG excursion, so a CPU answer pending during a player error is still judged on return.
- HP updates happen once, on the RESULT entry cycle:
  - JUDG 01: C_HP decrements.
  - JUDG 10: P_HP decrements.
  - JUDG 11: no change.
  - Decrements saturate at 0.
  - HP_STAT is set in the same cycle the relevant HP reaches 0: 01 for C_HP, 10 for P_HP. It is sticky until NEW_GAME or reset.
- NEW_GAME overrides everything: reload HP, clear HP_STAT, JUDG, WRONG and latches, go to IDLE.

## Timing
- A submit sampled at edge N sets the latch at N and ACK is high in cycle N+1. COLLECT dispatches at edge N+1. The CHK_* result is registered at edge N+2. JUDG is visible 2 cycles after the submit edge, or 3 cycles when both sides go through CHK_P then CHK_C.
- A CPU submit arriving during CHK_P is latched in time to be judged via p_ok, so it can produce a DRAW.
- A player submit during CHK_C is latched, but it is ignored if the CPU matches.
- Only one comparison is made per cycle; EXP_ANS is never compared against both answers in one cycle.
- HP and HP_STAT update one edge after the JUDG edge.
- Deasserting RST_N mid-round immediately forces all reset values; no pending result survives.

## Test plan
- EXP_ANS=12, P_DEC with P_ANS=12 in INPUT -> P_ACK at +1, JUDG=01 at +2, C_HP 3->2 at +3. STATE=0010 -> JUDG=00.
- P_ANS=5 (wrong) -> WRONG=11. STATE goes 0111 -> WRONG=00, and a new P_DEC is accepted after return to 0100.
- P_DEC and C_VALID in the same cycle, both answers 12 -> CHK_P then CHK_C, JUDG=11, HP unchanged.
- C_ANS=12 alone three rounds with HP_INIT=3 -> P_HP 2,1,0. HP_STAT=10 on the third RESULT edge. Extra OUCH keeps P_HP=0.
- CPU wrong answer (7) then player correct -> no ACK on a second C_VALID while its latch is full. The wrong CPU answer is silently dropped; JUDG=01.
- Assert NEW_GAME while in RESULT, and separately pull RST_N low mid-CHK_P -> both give HP=3, JUDG=00, IDLE.
